// File: rtl/minterm_func_unit_pkg.sv
// Shared types and constants for the minterm function unit: config FSM states,
// decoded-line count, and the reset mask for the 4-input configuration.
package minterm_func_unit_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE   = 2'd0,
    CFG_LOAD   = 2'd1,
    CFG_COMMIT = 2'd2
  } cfg_state_e;

  // Minterms 2,3,5,7,11,13
  localparam logic [15:0] DEFAULT_MASK_N4 = 16'h28AC;

  function automatic int calc_m(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/minterm_func_unit_onehot_decoder.sv
// Combinational N-to-2^N one-hot decoder; en_i=0 forces every line low.
module minterm_func_unit_onehot_decoder
  import minterm_func_unit_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                      en_i,
  input  logic [N_IN-1:0]           sel_i,
  output logic [calc_m(N_IN)-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/minterm_func_unit.sv
// Two-stage streaming sum-of-minterms unit with a serially loaded mask that is
// committed only once the pipeline has drained, so every result sees one mask.
//
// state      | meaning
// CFG_IDLE   | mask stable, waiting for cfg_start
// CFG_LOAD   | shifting cfg bits into shadow, traffic uses old mask
// CFG_COMMIT | input blocked, waiting for pipeline to empty, then mask <= shadow
module minterm_func_unit
  import minterm_func_unit_pkg::*;
#(
  parameter int                      N_IN         = 4,
  parameter logic [calc_m(N_IN)-1:0] DEFAULT_MASK = DEFAULT_MASK_N4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [N_IN-1:0]         in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_f,
  output logic [calc_m(N_IN)-1:0] out_onehot,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  input  logic                    cfg_bit,
  output logic                    cfg_busy,
  output logic                    cfg_done
);

  localparam int M     = calc_m(N_IN);
  localparam int CNT_W = $clog2(M) + 1;

  cfg_state_e       state_q, state_d;
  logic [M-1:0]     mask_q, shadow_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cfg_done_q;

  logic             s1_valid_q;
  logic [M-1:0]     s1_onehot_q;
  logic             out_valid_q, out_f_q;
  logic [M-1:0]     out_onehot_q;

  logic [M-1:0]     dec_onehot;
  logic             s2_adv, s1_adv, accept, pipe_drained, last_bit;
  logic             cnt_clr, shift_en, commit_fire;

  minterm_func_unit_onehot_decoder #(.N_IN(N_IN)) u_dec (
    .en_i     (en),
    .sel_i    (in_data),
    .onehot_o (dec_onehot)
  );

  assign s2_adv       = !out_valid_q || out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign accept       = in_valid && in_ready;
  // Nothing in S1 and S2 empty or handing off this cycle: safe to swap masks
  assign pipe_drained = !s1_valid_q && s2_adv;
  assign last_bit     = (cnt_q == CNT_W'(M - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CFG_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CFG_IDLE:   if (cfg_start) state_d = CFG_LOAD;
      CFG_LOAD:   if (!cfg_start && cfg_valid && last_bit) state_d = CFG_COMMIT;
      CFG_COMMIT: if (pipe_drained) state_d = CFG_IDLE;
      default:    state_d = CFG_IDLE;
    endcase
  end

  always_comb begin
    cnt_clr     = 1'b0;
    shift_en    = 1'b0;
    commit_fire = 1'b0;
    cfg_busy    = 1'b1;
    in_ready    = s1_adv;
    unique case (state_q)
      CFG_IDLE: begin
        cfg_busy = 1'b0;
        cnt_clr  = cfg_start;
      end
      CFG_LOAD: begin
        cnt_clr  = cfg_start;
        shift_en = cfg_valid && !cfg_start;
      end
      CFG_COMMIT: begin
        in_ready    = 1'b0;
        commit_fire = pipe_drained;
      end
      default: cfg_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= DEFAULT_MASK;
      shadow_q   <= '0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= commit_fire;
      if (cnt_clr)       cnt_q <= '0;
      else if (shift_en) cnt_q <= cnt_q + CNT_W'(1);
      if (shift_en)      shadow_q <= {shadow_q[M-2:0], cfg_bit};
      if (commit_fire)   mask_q <= shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_onehot_q  <= '0;
      out_valid_q  <= 1'b0;
      out_f_q      <= 1'b0;
      out_onehot_q <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= accept;
        if (accept) s1_onehot_q <= dec_onehot;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_f_q      <= |(s1_onehot_q & mask_q);
          out_onehot_q <= s1_onehot_q;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_onehot = out_onehot_q;
  assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_minterm_func_unit.sv
// Directed bench for minterm_func_unit with a transaction-level reference model
// checked on every output handshake, plus literal expectations per scenario.
module tb_minterm_func_unit;

  localparam int M = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_f;
  logic [15:0] out_onehot;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_bit = 1'b0;
  logic        cfg_busy;
  logic        cfg_done;

  always #5 clk = ~clk;

  minterm_func_unit #(.N_IN(4), .DEFAULT_MASK(16'h28AC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_onehot(out_onehot), .cfg_start(cfg_start),
    .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: mask in force for each accepted word, expected results queue
  typedef struct { logic f; logic [15:0] oh; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] m_mask = 16'h28AC;
  logic [15:0] m_shadow = '0;
  int          m_cnt = 0;
  bit          m_loading = 0;
  bit          m_commit = 0;
  logic        got_f[$];
  logic [15:0] got_oh[$];
  int          n_acc = 0, n_done = 0, cyc = 0;
  int          first_acc = -1, first_out = -1, last_out = -1;
  bit          meas = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_mask = 16'h28AC; m_shadow = '0; m_cnt = 0; m_loading = 0; m_commit = 0;
    end else begin
      if (cfg_done) begin
        n_done++;
        chk("cfg_done_when_pending", {31'd0, m_commit}, 32'd1);
        m_commit = 0;
      end
      if (out_ready) chk("in_ready_vs_commit", {31'd0, in_ready}, {31'd0, !m_commit});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_f", {31'd0, out_f}, {31'd0, e.f});
          chk("out_onehot", {16'd0, out_onehot}, {16'd0, e.oh});
          got_f.push_back(out_f);
          got_oh.push_back(out_onehot);
          if (meas) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
          end
        end
      end
      if (in_valid && in_ready) begin
        e.oh = en ? (16'h1 << in_data) : 16'h0;
        e.f  = en ? m_mask[in_data] : 1'b0;
        exp_q.push_back(e);
        n_acc++;
        if (meas && first_acc < 0) first_acc = cyc;
      end
      if (cfg_start && !m_commit) begin
        m_loading = 1; m_cnt = 0;
      end else if (m_loading && cfg_valid) begin
        m_shadow = {m_shadow[14:0], cfg_bit};
        m_cnt++;
        if (m_cnt == M) begin
          m_loading = 0; m_commit = 1; m_mask = m_shadow;
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic e_v);
    int t = 0;
    logic acc = 1'b0;
    in_valid = 1'b1; in_data = d; en = e_v;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
      if (t > 200) begin
        chk("send_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk); t++;
    end
    if (t >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic cfg_pulse_start();
    cfg_start = 1'b1; @(posedge clk); #1; cfg_start = 1'b0;
  endtask

  task automatic cfg_send(input logic [15:0] v, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) begin
      cfg_valid = 1'b1; cfg_bit = v[i]; @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 100) begin
      @(negedge clk); t++;
    end
    if (t >= 100) chk("cfg_done_timeout", n_done - d0, 32'd1);
    @(posedge clk); #1;
  endtask

  int t1_exp[16] = '{0,0,1,1,0,1,0,1,0,0,0,1,0,1,0,0};
  int acc0, d0;
  logic [15:0] seq6[5] = '{16'd0, 16'd4, 16'd9, 16'd14, 16'd15};

  initial begin
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_f", {31'd0, out_f}, 32'd0);
    chk("rst_out_onehot", {16'd0, out_onehot}, 32'd0);
    chk("rst_cfg_busy", {31'd0, cfg_busy}, 32'd0);
    chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back sweep 0..15
    got_f.delete(); got_oh.delete(); meas = 1;
    for (int d = 0; d < 16; d++) send(4'(d), 1'b1);
    drain();
    meas = 0;
    chk("t1_count", got_f.size(), 32'd16);
    for (int i = 0; i < got_f.size() && i < 16; i++)
      chk("t1_f_seq", {31'd0, got_f[i]}, t1_exp[i]);
    chk("t1_latency", first_out - first_acc, 32'd2);
    chk("t1_throughput", last_out - first_out, 32'd15);

    // Enable gating
    got_f.delete(); got_oh.delete();
    send(4'd5, 1'b0);
    send(4'd5, 1'b1);
    drain();
    chk("t2_count", got_f.size(), 32'd2);
    if (got_f.size() == 2) begin
      chk("t2_en0_oh", {16'd0, got_oh[0]}, 32'h0);
      chk("t2_en0_f", {31'd0, got_f[0]}, 32'd0);
      chk("t2_en1_oh", {16'd0, got_oh[1]}, 32'h0020);
      chk("t2_en1_f", {31'd0, got_f[1]}, 32'd1);
    end

    // Backpressure
    got_f.delete(); got_oh.delete();
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin send(4'd3, 1'b1); send(4'd4, 1'b1); send(4'd7, 1'b1); end
    join_none
    repeat (4) @(negedge clk);
    chk("t3_accepted", n_acc - acc0, 32'd2);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_hold_f", {31'd0, out_f}, 32'd1);
    chk("t3_hold_oh", {16'd0, out_onehot}, 32'h0008);
    @(negedge clk);
    chk("t3_stable_oh", {16'd0, out_onehot}, 32'h0008);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("t3_count", got_f.size(), 32'd3);
    if (got_f.size() == 3) begin
      chk("t3_f0", {31'd0, got_f[0]}, 32'd1);
      chk("t3_f1", {31'd0, got_f[1]}, 32'd0);
      chk("t3_f2", {31'd0, got_f[2]}, 32'd1);
    end

    // Mask reload while streaming
    got_f.delete(); got_oh.delete();
    d0 = n_done;
    fork
      begin cfg_pulse_start(); cfg_send(16'h8001, 16); end
      begin
        send(4'd0, 1'b1); send(4'd15, 1'b1);
        repeat (14) @(posedge clk); #1;
        send(4'd0, 1'b1); send(4'd15, 1'b1);
      end
    join
    wait_done(d0);
    drain();
    chk("t4_done_count", n_done - d0, 32'd1);
    chk("t4_busy_after", {31'd0, cfg_busy}, 32'd0);
    if (got_f.size() >= 2) begin
      chk("t4_old_f0", {31'd0, got_f[0]}, 32'd0);
      chk("t4_old_f15", {31'd0, got_f[1]}, 32'd0);
    end
    got_f.delete(); got_oh.delete();
    send(4'd0, 1'b1); send(4'd15, 1'b1);
    drain();
    chk("t4_new_count", got_f.size(), 32'd2);
    if (got_f.size() == 2) begin
      chk("t4_new_f0", {31'd0, got_f[0]}, 32'd1);
      chk("t4_new_f15", {31'd0, got_f[1]}, 32'd1);
    end

    // Async reset mid-load
    cfg_pulse_start();
    cfg_send(16'hAAAA, 7);
    chk("t5_busy_before", {31'd0, cfg_busy}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy_async", {31'd0, cfg_busy}, 32'd0);
    chk("t5_valid_async", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    got_f.delete(); got_oh.delete();
    send(4'd2, 1'b1);
    drain();
    chk("t5_count", got_f.size(), 32'd1);
    if (got_f.size() == 1) chk("t5_default_f", {31'd0, got_f[0]}, 32'd1);

    // Restarted load, then all-ones mask
    d0 = n_done;
    cfg_pulse_start();
    cfg_send(16'h0000, 10);
    cfg_pulse_start();
    cfg_send(16'hFFFF, 16);
    wait_done(d0);
    repeat (5) @(posedge clk); #1;
    chk("t6_done_count", n_done - d0, 32'd1);
    got_f.delete(); got_oh.delete();
    for (int i = 0; i < 5; i++) send(seq6[i][3:0], 1'b1);
    drain();
    chk("t6_count", got_f.size(), 32'd5);
    for (int i = 0; i < got_f.size(); i++) chk("t6_all_ones", {31'd0, got_f[i]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
